adc_spi_master: RTL and testbench
=================================

// Module: adc_spi_master
// PURPOSE
// SPI master for the 16-channel 10-bit board ADC; direct upstream feeder of the auto ADC updater.
// - Takes a one-cycle adc_go plus adc_chan, runs one SPI frame and returns the 10-bit sample.
// - Result is adc_in, qualified by a one-cycle adc_valid pulse.
// - Runs entirely in the clk3p2M domain; SCLK is derived from it by a counter (no second clock).
// PARAMETERS
// FRAME_BITS   16  SCLK periods per frame (>=DATA_MSB+1, >=5)
// DATA_MSB     11  index in received word (MSB-first, bit FRAME_BITS-1 first) of sample MSB; sample = rx[DATA_MSB -: 10]
// HALF_PERIOD  1   clk3p2M cycles per SCLK half-period (>=1)
// CS_LEAD      1   cycles cs_n low before first SCLK falling edge (>=1)
// QUIET        2   cycles cs_n high after frame before next go accepted (>=1)
// PORTS
// clk3p2M     in   1   system clock (3.2 MHz); the only clock
// rst_n       in   1   synchronous active-low reset, sampled on clk3p2M rising edge
// adc_go      in   1   start request, sampled only in IDLE
// adc_chan    in   4   channel to convert, latched on accepted go
// adc_in      out  10  last converted sample, held until next valid
// adc_valid   out  1   one-cycle pulse: adc_in updated this cycle
// adc_busy    out  1   high in every state except IDLE
// adc_cs_n    out  1   ADC chip select, active low
// adc_sclk    out  1   SPI clock, idle high (CPOL=1, CPHA=1)
// adc_mosi    out  1   command bit to ADC
// adc_miso    in   1   data bit from ADC (already synchronous to board timing, no resync)
// BEHAVIOUR
// Reset (rst_n=0 at edge): state=IDLE, adc_in=0, adc_valid=0, adc_busy=0, adc_cs_n=1, adc_sclk=1, adc_mosi=0, shift regs/counters=0.
// - Applies from any state, mid-frame included: next cycle cs_n=1, sclk=1; no valid for the aborted frame.
// Command word (MSB first): {1'b1, chan[3:0], (FRAME_BITS-5) zeros}.
// States:
// - IDLE: cs_n=1, sclk=1. adc_go=1 -> latch chan, load tx word, mosi=tx[MSB], go to SETUP.
// - SETUP: cs_n=0, sclk=1 for CS_LEAD cycles, then SHIFT.
// - SHIFT: FRAME_BITS SCLK periods, each = HALF_PERIOD cycles low then HALF_PERIOD cycles high.
//   - mosi advances to next tx bit at every falling edge except the first (bit MSB already driven).
//   - miso is shifted into rx at the clk edge that drives sclk 0->1.
//   - After the last high phase go to HOLD.
// - HOLD: 1 cycle, cs_n=0, sclk=1; then DONE.
// - DONE: 1 cycle, cs_n=1, adc_in<=rx[DATA_MSB -: 10], adc_valid=1; then QUIET.
// - QUIET: cs_n=1 for QUIET cycles, then IDLE.
// Latency:
// - adc_valid is high exactly CS_LEAD+2*HALF_PERIOD*FRAME_BITS+2 cycles after the edge that accepted go (35 at defaults).
// - Min go-to-go spacing: that latency + QUIET (37 at defaults).
// adc_go while busy: ignored, not queued. go held high: re-accepted on first IDLE cycle.
// adc_chan changes after acceptance have no effect on the running frame.
// Counters: half-period counter width clog2(HALF_PERIOD)+1, bit counter clog2(FRAME_BITS)+1; no wrap inside a frame.
// adc_valid is never asserted in any cycle without a completed HOLD.
// TESTING
// 1 Reset then idle 100 cycles, no go -> cs_n=1, sclk=1, valid never 1, adc_in=0.
// 2 go, chan=4'hA; ADC model drives 0x0ABC pattern -> mosi frame 0xD000, 16 SCLK falls, valid at cycle 35, adc_in=rx[11:2]=10'h2AF.
// 3 go pulsed again at cycles 5 and 30 of a frame -> both ignored, one frame, one valid; chan latched from first go.
// 4 rst_n low at cycle 20 mid-frame -> next cycle cs_n=1, sclk=1, busy=0, no valid; later go runs a clean frame.
// 5 go held high, chans 0..15 stepped -> back-to-back frames every 37 cycles, each adc_in matches model channel value.
// 6 HALF_PERIOD=3 build -> sclk period 6 cycles, valid at 1+96+2=99 cycles, data correct.

Source files
------------

// File: rtl/adc_spi_master.sv
// adc_spi_master
// SPI master for the 16-channel 10-bit board ADC. A one-cycle adc_go starts
// one chip-select frame. The frame sends the command word {1, chan, zeros}
// MSB first on adc_mosi and collects adc_miso. The 10-bit sample is returned
// on adc_in together with a one-cycle adc_valid pulse. SCLK is generated from
// clk3p2M by a counter (CPOL=1, CPHA=1), so there is only one clock domain.
//
// Ports
//   clk3p2M    in   system clock, the only clock
//   rst_n      in   synchronous active-low reset
//   adc_go     in   start request, sampled only while idle
//   adc_chan   in   [3:0] channel, latched into the command word on accept
//   adc_in     out  [9:0] last converted sample, held until next valid
//   adc_valid  out  one-cycle pulse when adc_in is updated
//   adc_busy   out  high whenever not idle
//   adc_cs_n   out  ADC chip select, active low
//   adc_sclk   out  SPI clock, idles high
//   adc_mosi   out  command bit to the ADC
//   adc_miso   in   data bit from the ADC
module adc_spi_master #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_MSB    = 11,
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned CS_LEAD     = 1,
  parameter int unsigned QUIET       = 2
) (
  input  logic       clk3p2M,
  input  logic       rst_n,
  input  logic       adc_go,
  input  logic [3:0] adc_chan,
  output logic [9:0] adc_in,
  output logic       adc_valid,
  output logic       adc_busy,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_mosi,
  input  logic       adc_miso
);

  localparam int unsigned HW = $clog2(HALF_PERIOD) + 1;
  localparam int unsigned BW = $clog2(FRAME_BITS) + 1;
  localparam int unsigned LW = $clog2(CS_LEAD + QUIET) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE,
    S_QUIET
  } state_e;

  state_e                  state_q;
  logic [FRAME_BITS-1:0]   tx_q;
  logic [9:0]              rx_q;
  logic [HW-1:0]           half_q;
  logic [BW-1:0]           bit_q;
  logic [LW-1:0]           cnt_q;
  logic [9:0]              adc_in_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    cs_n_q;
  logic                    sclk_q;
  logic                    mosi_q;

  logic [FRAME_BITS-1:0]   tx_d;
  logic                    rx_take_d;

  // Command word: start bit and channel in the top five bits, zeros below.
  always_comb begin
    tx_d = FRAME_BITS'({1'b1, adc_chan}) << (FRAME_BITS - 5);
  end

  // Only the ten received bits that form the sample are kept. Bit number
  // bit_q arrives as word bit FRAME_BITS-1-bit_q, so the window
  // DATA_MSB..DATA_MSB-9 maps onto these bit_q values.
  always_comb begin
    rx_take_d = (bit_q >= BW'(FRAME_BITS - 1 - DATA_MSB)) &&
                (bit_q <= BW'(FRAME_BITS - 1 - DATA_MSB + 9));
  end

  always_ff @(posedge clk3p2M) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      half_q   <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      adc_in_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (adc_go) begin
            state_q <= S_SETUP;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            tx_q    <= tx_d;
            mosi_q  <= tx_d[FRAME_BITS-1];
            rx_q    <= '0;
            cnt_q   <= '0;
          end
        end
        S_SETUP: begin
          if (cnt_q == LW'(CS_LEAD - 1)) begin
            state_q <= S_SHIFT;
            sclk_q  <= 1'b0;
            half_q  <= '0;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          if (half_q != HW'(HALF_PERIOD - 1)) begin
            half_q <= half_q + 1'b1;
          end else begin
            half_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              if (rx_take_d) begin
                rx_q <= {rx_q[8:0], adc_miso};
              end
            end else if (bit_q == BW'(FRAME_BITS - 1)) begin
              state_q <= S_HOLD;
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 1'b1;
              mosi_q <= tx_q[FRAME_BITS-2];
              tx_q   <= tx_q << 1;
            end
          end
        end
        S_HOLD: begin
          state_q  <= S_DONE;
          cs_n_q   <= 1'b1;
          mosi_q   <= 1'b0;
          valid_q  <= 1'b1;
          adc_in_q <= rx_q;
        end
        S_DONE: begin
          // The first idle cycle counts as the last quiet cycle, so QUIET
          // cs_n-high cycles follow DONE before the next go can take effect.
          cnt_q <= '0;
          if (QUIET > 1) begin
            state_q <= S_QUIET;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_QUIET: begin
          if (cnt_q == LW'(QUIET - 2)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b1;
        end
      endcase
    end
  end

  assign adc_in    = adc_in_q;
  assign adc_valid = valid_q;
  assign adc_busy  = busy_q;
  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign adc_mosi  = mosi_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Testbench for adc_spi_master: default build (dut0) plus a HALF_PERIOD=3
// build (dut1). A behavioural ADC returns a random 16-bit word per channel
// MSB first. The expected sample is the word's bits [11:2].
module tb_adc_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  logic [15:0] chan_word [16];

  // ---------------- dut0: default parameters ----------------
  logic       go0 = 1'b0;
  logic [3:0] chan0 = '0;
  logic [9:0] in0;
  logic       valid0, busy0, cs_n0, sclk0, mosi0;
  logic       miso0 = 1'b0;

  adc_spi_master dut0 (
    .clk3p2M  (clk),
    .rst_n    (rst_n),
    .adc_go   (go0),
    .adc_chan (chan0),
    .adc_in   (in0),
    .adc_valid(valid0),
    .adc_busy (busy0),
    .adc_cs_n (cs_n0),
    .adc_sclk (sclk0),
    .adc_mosi (mosi0),
    .adc_miso (miso0)
  );

  // ---------------- dut1: slow SCLK ----------------
  logic       go1 = 1'b0;
  logic [3:0] chan1 = '0;
  logic [9:0] in1;
  logic       valid1, busy1, cs_n1, sclk1, mosi1;
  logic       miso1 = 1'b0;

  adc_spi_master #(.HALF_PERIOD(3)) dut1 (
    .clk3p2M  (clk),
    .rst_n    (rst_n),
    .adc_go   (go1),
    .adc_chan (chan1),
    .adc_in   (in1),
    .adc_valid(valid1),
    .adc_busy (busy1),
    .adc_cs_n (cs_n1),
    .adc_sclk (sclk1),
    .adc_mosi (mosi1),
    .adc_miso (miso1)
  );

  // ---------------- ADC models and bus monitors ----------------
  logic [15:0] resp0 = '0, resp1 = '0;
  logic [15:0] cap0 = '0, cap1 = '0;
  int idx0 = 0, idx1 = 0, falls0 = 0, falls1 = 0;
  int vcnt0 = 0, vcnt1 = 0;
  logic cslow0 = 1'b0;

  always @(negedge cs_n0) begin idx0 = 0; cap0 = '0; falls0 = 0; end
  always @(negedge sclk0) begin
    if (idx0 < 16) miso0 = resp0[15 - idx0];
    idx0++;
    falls0++;
  end
  always @(posedge sclk0) if (!cs_n0) cap0 = {cap0[14:0], mosi0};

  always @(negedge cs_n1) begin idx1 = 0; cap1 = '0; falls1 = 0; end
  always @(negedge sclk1) begin
    if (idx1 < 16) miso1 = resp1[15 - idx1];
    idx1++;
    falls1++;
  end
  always @(posedge sclk1) if (!cs_n1) cap1 = {cap1[14:0], mosi1};

  always @(negedge clk) begin
    if (valid0 === 1'b1) vcnt0++;
    if (valid1 === 1'b1) vcnt1++;
    if (cs_n0 === 1'b0) cslow0 = 1'b1;
  end

  // ---------------- reference and helpers ----------------
  function automatic logic [9:0] sample_of(input logic [15:0] w);
    return 10'((w >> 2) & 16'h03FF);
  endfunction

  function automatic logic [15:0] cmd_of(input logic [3:0] c);
    return 16'h8000 | (16'(c) << 11);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame0(input logic [3:0] c, output int lat);
    resp0 = chan_word[c];
    @(negedge clk);
    go0 = 1'b1;
    chan0 = c;
    @(posedge clk);
    #1 go0 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (valid0) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (busy0 !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'(busy0), 32'd0);
  endtask

  int lat;
  int vbase;
  int prev_t;
  logic [3:0] rc;

  initial begin
    for (int c = 0; c < 16; c++) chan_word[c] = 16'($urandom);
    chan_word[10] = 16'h0ABC;

    // 1: reset, then idle with no go
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(cs_n0), 32'd1);
    check("rst_sclk", 32'(sclk0), 32'd1);
    check("rst_adc_in", 32'(in0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_mosi", 32'(mosi0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt0 = 0;
    cslow0 = 1'b0;
    falls0 = 0;
    repeat (100) @(negedge clk);
    check("idle_valid_cnt", 32'(vcnt0), 32'd0);
    check("idle_cs_low", 32'(cslow0), 32'd0);
    check("idle_sclk_falls", 32'(falls0), 32'd0);
    check("idle_adc_in", 32'(in0), 32'd0);

    // 2: channel A, ADC word 0x0ABC
    vbase = vcnt0;
    frame0(4'hA, lat);
    check("t2_latency", 32'(lat), 32'd35);
    check("t2_adc_in", 32'(in0), 32'h2AF);
    check("t2_mosi_frame", 32'(cap0), 32'hD000);
    check("t2_sclk_falls", 32'(falls0), 32'd16);
    check("t2_cs_n_done", 32'(cs_n0), 32'd1);
    wait_idle0();
    repeat (5) @(negedge clk);
    check("t2_valid_cnt", 32'(vcnt0 - vbase), 32'd1);

    // 3: extra go pulses during a frame are ignored
    resp0 = chan_word[6];
    vbase = vcnt0;
    @(negedge clk);
    go0 = 1'b1;
    chan0 = 4'h6;
    @(posedge clk);
    #1 go0 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 5 || n == 30) begin
        check("t3_busy_at_go", 32'(busy0), 32'd1);
        go0 = 1'b1;
        chan0 = 4'h3;
      end else begin
        go0 = 1'b0;
      end
      if (valid0 && lat < 0) lat = n;
    end
    check("t3_latency", 32'(lat), 32'd35);
    check("t3_valid_cnt", 32'(vcnt0 - vbase), 32'd1);
    check("t3_mosi_frame", 32'(cap0), 32'(cmd_of(4'h6)));
    check("t3_adc_in", 32'(in0), 32'(sample_of(chan_word[6])));
    check("t3_busy_after", 32'(busy0), 32'd0);

    // 4: reset in the middle of a frame
    resp0 = chan_word[9];
    @(negedge clk);
    go0 = 1'b1;
    chan0 = 4'h9;
    @(posedge clk);
    #1 go0 = 1'b0;
    repeat (20) @(negedge clk);
    vbase = vcnt0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t4_cs_n", 32'(cs_n0), 32'd1);
    check("t4_sclk", 32'(sclk0), 32'd1);
    check("t4_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t4_no_valid", 32'(vcnt0 - vbase), 32'd0);
    rc = 4'($urandom_range(15));
    frame0(rc, lat);
    check("t4_clean_latency", 32'(lat), 32'd35);
    check("t4_clean_adc_in", 32'(in0), 32'(sample_of(chan_word[rc])));
    check("t4_clean_mosi", 32'(cap0), 32'(cmd_of(rc)));
    wait_idle0();

    // 5: go held high, channels 0..15 back to back
    @(negedge clk);
    chan0 = 4'h0;
    resp0 = chan_word[0];
    go0 = 1'b1;
    prev_t = -1;
    for (int k = 0; k < 16; k++) begin
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
        @(negedge clk);
        if (valid0) begin
          lat = n;
          break;
        end
      end
      check("t5_valid_seen", 32'(lat > 0), 32'd1);
      check("t5_adc_in", 32'(in0), 32'(sample_of(chan_word[k])));
      if (prev_t >= 0) check("t5_spacing", 32'(cyc - prev_t), 32'd37);
      prev_t = cyc;
      if (k < 15) begin
        chan0 = 4'(k + 1);
        resp0 = chan_word[k + 1];
      end else begin
        go0 = 1'b0;
      end
    end
    wait_idle0();

    // 6: HALF_PERIOD=3 build
    rc = 4'($urandom_range(15));
    resp1 = chan_word[rc];
    vbase = vcnt1;
    @(negedge clk);
    go1 = 1'b1;
    chan1 = rc;
    @(posedge clk);
    #1 go1 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 8) check("t6_sclk_low", 32'(sclk1), 32'd0);
      if (n == 11) check("t6_sclk_high", 32'(sclk1), 32'd1);
      if (valid1) begin
        lat = n;
        break;
      end
    end
    check("t6_latency", 32'(lat), 32'd99);
    check("t6_adc_in", 32'(in1), 32'(sample_of(chan_word[rc])));
    check("t6_mosi_frame", 32'(cap1), 32'(cmd_of(rc)));
    check("t6_sclk_falls", 32'(falls1), 32'd16);
    repeat (5) @(negedge clk);
    check("t6_valid_cnt", 32'(vcnt1 - vbase), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
